// File: rtl/i2c_slave_eeprom.sv
// i2c_slave_eeprom: I2C responder emulating a 24C02-style EEPROM.
// It holds 256 bytes of storage, takes a 1-byte word address and has an
// auto-incrementing pointer that wraps from 0xFF to 0x00.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   scl_pad_i         SCL line (never stretched by this block)
//   sda_pad_i         SDA line
//   sda_pad_o         constant 0 (open-drain data value)
//   sda_padoen_o      SDA output enable, active low (0 pulls SDA low)
//   mem_wr_en         one-clk pulse when a data byte is committed
//   mem_wr_addr/data  address and value of the committed byte
//   busy              high from an addressed START until STOP/NACK/mismatch
module i2c_slave_eeprom #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         SDA_HOLD = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_addr,
    output logic [7:0] mem_wr_data,
    output logic       busy
);

    localparam int HOLD_W = $clog2(SDA_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SDA_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_DEV, S_WADDR, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    // Synchronizers plus one delayed copy for edge detection.
    logic scl_s1_q, scl_s2_q, scl_d3_q;
    logic sda_s1_q, sda_s2_q, sda_d3_q;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;   // SCL rising edges in the 9-clock frame
    logic [6:0]        shift_q, shift_d;       // received bits; [0] is R/W after the dev byte
    logic [7:0]        tx_q, tx_d;             // read byte, shifted out MSB first
    logic [7:0]        ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              oen_q, oen_d;
    logic              hold_act_q, hold_act_d; // an SDA change is waiting for the hold time
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              pend_oen_q, pend_oen_d;

    logic [7:0] mem_q [256];

    logic       scl_rise, scl_fall, start_det, stop_det, commit;
    logic [7:0] rx_byte, ptr_inc;

    assign scl_rise  = scl_s2_q & ~scl_d3_q;
    assign scl_fall  = ~scl_s2_q & scl_d3_q;
    // SDA edges only count as START/STOP while SCL is stably high.
    assign start_det = scl_s2_q & scl_d3_q & sda_d3_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_d3_q & ~sda_d3_q & sda_s2_q;
    assign rx_byte   = {shift_q, sda_s2_q};
    assign ptr_inc   = ptr_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        oen_d      = oen_q;
        hold_act_d = hold_act_q;
        hold_cnt_d = hold_cnt_q;
        pend_oen_d = pend_oen_q;
        commit     = 1'b0;

        if (hold_act_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
                oen_d      = pend_oen_q;
                hold_act_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
        end

        if (start_det) begin
            state_d    = S_DEV;
            bit_cnt_d  = 4'd0;
            hold_act_d = 1'b0;
            oen_d      = 1'b1;
        end else if (stop_det) begin
            state_d    = S_IDLE;
            bit_cnt_d  = 4'd0;
            busy_d     = 1'b0;
            hold_act_d = 1'b0;
            oen_d      = 1'b1;
        end else if (scl_rise) begin
            case (state_q)
                S_DEV, S_WADDR, S_WDATA: begin
                    if (bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            // Eighth bit: the byte is complete.
                            case (state_q)
                                S_DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        busy_d = 1'b1;
                                    end else begin
                                        state_d = S_IGNORE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                S_WADDR: ptr_d = rx_byte;
                                default: begin
                                    commit    = 1'b1;
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = rx_byte;
                                    ptr_d     = ptr_inc;
                                end
                            endcase
                        end
                    end else begin
                        // Rising edge of the ACK clock.
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            S_DEV: begin
                                if (shift_q[0]) begin
                                    state_d = S_RDATA;
                                    tx_d    = mem_q[ptr_q];
                                end else begin
                                    state_d = S_WADDR;
                                end
                            end
                            S_WADDR: state_d = S_WDATA;
                            default: state_d = S_WDATA;
                        endcase
                    end
                end
                S_RDATA: begin
                    if (bit_cnt_q < 4'd8) begin
                        tx_d      = {tx_q[6:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
                        bit_cnt_d = 4'd0;
                        if (sda_s2_q) begin
                            state_d = S_IGNORE;
                            busy_d  = 1'b0;
                        end else begin
                            ptr_d = ptr_inc;
                            tx_d  = mem_q[ptr_inc];
                        end
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            // Every SDA change is scheduled from an SCL falling edge and
            // applied once the hold time has elapsed.
            hold_act_d = 1'b1;
            hold_cnt_d = '0;
            pend_oen_d = 1'b1;
            case (state_q)
                S_DEV, S_WADDR, S_WDATA: if (bit_cnt_q == 4'd8) pend_oen_d = 1'b0;
                S_RDATA:                 if (bit_cnt_q < 4'd8)  pend_oen_d = tx_q[7];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_d3_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_d3_q   <= 1'b1;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            tx_q       <= 8'd0;
            ptr_q      <= 8'd0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            oen_q      <= 1'b1;
            hold_act_q <= 1'b0;
            hold_cnt_q <= '0;
            pend_oen_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl_pad_i;
            scl_s2_q   <= scl_s1_q;
            scl_d3_q   <= scl_s2_q;
            sda_s1_q   <= sda_pad_i;
            sda_s2_q   <= sda_s1_q;
            sda_d3_q   <= sda_s2_q;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            oen_q      <= oen_d;
            hold_act_q <= hold_act_d;
            hold_cnt_q <= hold_cnt_d;
            pend_oen_q <= pend_oen_d;
        end
    end

    // Storage is deliberately left out of reset so it survives it.
    always_ff @(posedge clk) begin
        if (commit) mem_q[ptr_q] <= rx_byte;
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = oen_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_wr_addr  = wr_addr_q;
    assign mem_wr_data  = wr_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_slave_eeprom.sv
// Testbench for i2c_slave_eeprom: a bench-side I2C master drives the bus,
// expected ACK bits, read bytes and memory commits are queued by the
// stimulus and compared by a separate monitor process.
module tb_i2c_slave_eeprom;

    localparam int SDA_HOLD = 10;
    localparam int Q        = 20;   // quarter SCL period in clk cycles

    typedef struct {
        string name;
        int    val;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_pad_o, sda_padoen_o, mem_wr_en, busy;
    logic [7:0] mem_wr_addr, mem_wr_data;
    logic       sda_line;

    assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

    i2c_slave_eeprom #(.DEV_ADDR(7'h50), .SDA_HOLD(SDA_HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_pad_i    (scl_m),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    item_t exp_rx_q[$];
    item_t obs_rx_q[$];
    item_t exp_wr_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    timing_bad = 0;
    int    n_trans = 0;
    logic  saw_drive = 1'b0;
    logic  saw_busy = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp_rx(input string nm, input int v);
        item_t it;
        it.name = nm;
        it.val  = v;
        exp_rx_q.push_back(it);
    endtask

    task automatic push_obs_rx(input string nm, input int v);
        item_t it;
        it.name = nm;
        it.val  = v;
        obs_rx_q.push_back(it);
    endtask

    task automatic push_exp_wr(input string nm, input logic [7:0] a, input logic [7:0] d);
        item_t it;
        it.name = nm;
        it.val  = int'({a, d});
        exp_wr_q.push_back(it);
    endtask

    // Monitor: memory commits, bus responses and SDA timing.
    task automatic monitor_loop();
        item_t e;
        item_t o;
        logic  prev_scl = 1'b1;
        logic  prev_oen = 1'b1;
        int    cyc = 0;
        int    fall_cyc = 0;
        int    d;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_scl && !scl_m) fall_cyc = cyc;
            prev_scl = scl_m;
            if (!rst) begin
                if (busy) saw_busy = 1'b1;
                if (!sda_padoen_o) saw_drive = 1'b1;
                if (sda_padoen_o != prev_oen) begin
                    n_trans++;
                    d = cyc - fall_cyc;
                    if (scl_m || d < SDA_HOLD + 1 || d > SDA_HOLD + 5) begin
                        timing_bad++;
                        $display("sda transition outside window: delta=%0d scl=%0b", d, scl_m);
                    end
                end
                if (mem_wr_en) begin
                    if (exp_wr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL wr_unexpected: got addr=0x%0h data=0x%0h, required no write",
                                 mem_wr_addr, mem_wr_data);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check(e.name, int'({mem_wr_addr, mem_wr_data}), e.val);
                    end
                end
            end
            prev_oen = sda_padoen_o;
            while (obs_rx_q.size() > 0) begin
                o = obs_rx_q.pop_front();
                if (exp_rx_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s: got 0x%0h, required nothing", o.name, o.val);
                end else begin
                    e = exp_rx_q.pop_front();
                    check(e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic send_bit(input logic b, output logic r);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        r = sda_line;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
        logic r;
        push_exp_rx(nm, int'(exp_ack));
        for (int i = 7; i >= 0; i--) send_bit(b[i], r);
        send_bit(1'b1, r);
        push_obs_rx(nm, int'(r));
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic mack, input string nm);
        logic       r;
        logic [7:0] d;
        d = 8'h00;
        push_exp_rx(nm, int'(exp));
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, r);
            d = {d[6:0], r};
        end
        send_bit(mack, r);
        push_obs_rx(nm, int'(d));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_padoen"}, int'(sda_padoen_o), 1);
        check({tag, "_pad_o"},  int'(sda_pad_o),    0);
        check({tag, "_wr_en"},  int'(mem_wr_en),    0);
        check({tag, "_wr_addr"}, int'(mem_wr_addr), 0);
        check({tag, "_wr_data"}, int'(mem_wr_data), 0);
        check({tag, "_busy"},   int'(busy),         0);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none

        wait_clk(5);
        check_reset_outputs("rst");
        rst = 1'b0;
        wait_clk(10);

        // Byte write then random read.
        i2c_start();
        write_byte(8'hA0, 1'b0, "t1_ack_dev");
        write_byte(8'h00, 1'b0, "t1_ack_addr");
        check("t1_busy_high", int'(busy), 1);
        push_exp_wr("t1_commit", 8'h00, 8'h5A);
        write_byte(8'h5A, 1'b0, "t1_ack_data");
        i2c_stop();
        check("t1_busy_after_stop", int'(busy), 0);
        i2c_start();
        write_byte(8'hA0, 1'b0, "t1_rd_ack_dev");
        write_byte(8'h00, 1'b0, "t1_rd_ack_addr");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t1_rd_ack_a1");
        read_byte(8'h5A, 1'b1, "t1_read_data");
        check("t1_busy_after_nack", int'(busy), 0);
        check("t1_sda_released", int'(sda_padoen_o), 1);
        i2c_stop();

        // Sequential write across the 0xFF -> 0x00 wrap, then read back.
        i2c_start();
        write_byte(8'hA0, 1'b0, "t2_ack_dev");
        write_byte(8'hFE, 1'b0, "t2_ack_addr");
        push_exp_wr("t2_commit_fe", 8'hFE, 8'h11);
        push_exp_wr("t2_commit_ff", 8'hFF, 8'h22);
        push_exp_wr("t2_commit_00", 8'h00, 8'h33);
        write_byte(8'h11, 1'b0, "t2_ack_d0");
        write_byte(8'h22, 1'b0, "t2_ack_d1");
        write_byte(8'h33, 1'b0, "t2_ack_d2");
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t2_rd_ack_dev");
        write_byte(8'hFE, 1'b0, "t2_rd_ack_addr");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t2_rd_ack_a1");
        read_byte(8'h11, 1'b0, "t2_read_fe");
        read_byte(8'h22, 1'b0, "t2_read_ff");
        read_byte(8'h33, 1'b1, "t2_read_00");
        i2c_stop();

        // Address mismatch, then a normal transaction.
        saw_drive = 1'b0;
        saw_busy  = 1'b0;
        i2c_start();
        write_byte(8'hA2, 1'b1, "t3_nack_dev");
        write_byte(8'h33, 1'b1, "t3_nack_data");
        i2c_stop();
        check("t3_sda_never_low", int'(saw_drive), 0);
        check("t3_busy_never_high", int'(saw_busy), 0);
        i2c_start();
        write_byte(8'hA0, 1'b0, "t3_ack_dev");
        write_byte(8'h30, 1'b0, "t3_ack_addr");
        push_exp_wr("t3_commit", 8'h30, 8'h77);
        write_byte(8'h77, 1'b0, "t3_ack_data");
        i2c_stop();

        // STOP in the middle of a data byte.
        i2c_start();
        write_byte(8'hA0, 1'b0, "t4_pre_ack_dev");
        write_byte(8'h10, 1'b0, "t4_pre_ack_addr");
        push_exp_wr("t4_pre_commit", 8'h10, 8'hC3);
        write_byte(8'hC3, 1'b0, "t4_pre_ack_data");
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t4_ack_dev");
        write_byte(8'h10, 1'b0, "t4_ack_addr");
        begin
            logic       r;
            logic [3:0] part;
            part = 4'b1010;
            for (int i = 3; i >= 0; i--) send_bit(part[i], r);
        end
        i2c_stop();
        check("t4_busy_after_stop", int'(busy), 0);
        i2c_start();
        write_byte(8'hA1, 1'b0, "t4_ack_a1");
        read_byte(8'hC3, 1'b1, "t4_read_ptr");
        i2c_stop();

        // Reset while the slave drives a 0 data bit.
        i2c_start();
        write_byte(8'hA0, 1'b0, "t5_pre_ack_dev");
        write_byte(8'h20, 1'b0, "t5_pre_ack_addr");
        push_exp_wr("t5_pre_commit", 8'h20, 8'h0F);
        write_byte(8'h0F, 1'b0, "t5_pre_ack_data");
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t5_ack_dev");
        write_byte(8'h20, 1'b0, "t5_ack_addr");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t5_ack_a1");
        check("t5_slave_driving", int'(sda_padoen_o), 0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_release", int'(sda_padoen_o), 1);
        wait_clk(3);
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        wait_clk(5);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, 1'b0, "t5_rd_ack_dev");
        write_byte(8'h20, 1'b0, "t5_rd_ack_addr");
        i2c_start();
        write_byte(8'hA1, 1'b0, "t5_rd_ack_a1");
        read_byte(8'h0F, 1'b1, "t5_read_kept");
        i2c_stop();

        wait_clk(20);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rx_queue_drained", exp_rx_q.size(), 0);
        check("sda_transitions_seen", int'(n_trans > 0), 1);
        check("sda_timing_violations", timing_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
